// File: rtl/pad_event_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_evt_pkg
// Description : Shared event field layout for the pad event conditioner.
//               An event word is {is_press, channel index}, is_press on top.
// Revision    : 1.0 - initial release
// ============================================================================
package pad_evt_pkg;

  // Widest channel index the block supports (NUM_CH up to 64)
  localparam int MAX_CH_IDX_W = 6;

  // Channel index width; a single channel still gets one index bit
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Bit position of the is_press flag inside an event word
  function automatic int is_press_bit(input int num_ch);
    return ch_idx_w(num_ch);
  endfunction

  // Event at the widest supported index; narrowed when it enters the FIFO
  typedef struct packed {
    logic                    is_press;
    logic [MAX_CH_IDX_W-1:0] ch;
  } pad_evt_t;

endpackage
`default_nettype wire

// File: rtl/pad_event_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : pad_event_conditioner_if
// Description : Valid/ready event stream from the conditioner to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pad_event_conditioner_if
  import pad_evt_pkg::*;
#(
  parameter int NUM_CH = 24
);
  localparam int c_data_w = 1 + ch_idx_w(NUM_CH);

  logic                evt_valid;
  logic                evt_ready;
  logic [c_data_w-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pad_debounce
// Description : One channel: polarity normalise, 2-flop synchroniser,
//               stable-count debounce and registered press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_debounce #(
  parameter bit INVERT          = 1'b0,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic raw_i,
  output logic      level_o,
  output logic      press_o,
  output logic      release_o
);
  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         sync_q;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               level_dly_q;
  logic               press_q, release_q;

  // Normalise to active-high, then bring into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], raw_i ^ INVERT};
  end

  // Count consecutive differing cycles; accept the new level on the last one
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == c_cnt_last) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
  end

  // Debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Edge pulses appear the cycle after the level moves, for one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      release_q   <= ~level_q & level_dly_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule
`default_nettype wire

// File: rtl/pad_event_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pad_event_conditioner
// Description : N-channel pad front end: debounce, press/release pending
//               bits with coalesce counting, priority enqueue into a
//               show-ahead event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_event_conditioner
  import pad_evt_pkg::*;
#(
  parameter int                NUM_CH          = 24,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = '0,
  parameter int                DEBOUNCE_CYCLES = 250000,
  parameter int                FIFO_DEPTH      = 16,
  parameter int                DROP_W          = 16
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_ni,
  input  wire logic [NUM_CH-1:0]           raw_i,
  input  wire logic                        enable_i,
  output logic      [NUM_CH-1:0]           level_o,
  output logic      [NUM_CH-1:0]           press_pulse_o,
  output logic      [NUM_CH-1:0]           release_pulse_o,
  output logic      [$clog2(FIFO_DEPTH):0] evt_count_o,
  output logic      [DROP_W-1:0]           drop_count_o,
  input  wire logic                        clear_drops_i,
  pad_event_conditioner_if.master          evt_if
);
  localparam int c_idx_w  = ch_idx_w(NUM_CH);
  localparam int c_word_w = c_idx_w + 1;
  localparam int c_aw     = $clog2(FIFO_DEPTH);
  localparam int c_scan_w = 2 * NUM_CH;
  localparam int c_pop_w  = $clog2(c_scan_w + 1);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(FIFO_DEPTH);

  // ---- per-channel debounce ----
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pad_debounce #(
        .INVERT          (INVERT_MASK[gi]),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raw_i     (raw_i[gi]),
        .level_o   (level_o[gi]),
        .press_o   (press_pulse_o[gi]),
        .release_o (release_pulse_o[gi])
      );
    end
  endgenerate

  // ---- pending bits, scan order: presses then releases, low index first ----
  logic [NUM_CH-1:0]   pend_press_q, pend_rel_q;
  logic [c_scan_w-1:0] w_pend_all, w_pulse_all, w_grant, w_grant_eff, w_pend_nxt, w_drop_vec;
  logic                w_any;
  pad_evt_t            w_sel_evt;

  assign w_pend_all  = {pend_rel_q, pend_press_q};
  assign w_pulse_all = {release_pulse_o, press_pulse_o};

  // Pick the first pending event in scan order
  always_comb begin
    w_grant   = '0;
    w_any     = 1'b0;
    w_sel_evt = '0;
    for (int k = 0; k < c_scan_w; k++) begin
      if (!w_any && w_pend_all[k]) begin
        w_any              = 1'b1;
        w_grant[k]         = 1'b1;
        w_sel_evt.is_press = (k < NUM_CH);
        w_sel_evt.ch       = MAX_CH_IDX_W'(k % NUM_CH);
      end
    end
  end

  // Upper index bits are always zero for narrow channel counts
  generate
    if (c_idx_w < MAX_CH_IDX_W) begin : g_idx_unused
      logic w_unused_idx_hi;
      assign w_unused_idx_hi = ^w_sel_evt.ch[MAX_CH_IDX_W-1:c_idx_w];
    end
  endgenerate

  // ---- FIFO control ----
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]   count_q, count_d;
  logic            w_full, w_valid, w_push, w_pop;

  assign w_full  = (count_q == c_full);
  assign w_valid = (count_q != '0);
  assign w_pop   = w_valid & evt_if.evt_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push  = enable_i & w_any & (~w_full | w_pop);
  assign w_grant_eff = w_push ? w_grant : '0;

  // Coalesce detection: a pulse landing on a bit that stays set this cycle
  assign w_drop_vec = enable_i ? (w_pulse_all & w_pend_all & ~w_grant_eff) : '0;
  assign w_pend_nxt = enable_i ? ((w_pend_all & ~w_grant_eff) | w_pulse_all) : '0;
  assign count_d    = count_q + (c_aw + 1)'(w_push) - (c_aw + 1)'(w_pop);

  // Pending bits and FIFO pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      {pend_rel_q, pend_press_q} <= w_pend_nxt;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage
  logic [c_word_w-1:0] mem_q [FIFO_DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= {w_sel_evt.is_press, w_sel_evt.ch[c_idx_w-1:0]};
    end
  end

  assign evt_if.evt_valid = w_valid;
  assign evt_if.evt_data  = mem_q[rd_ptr_q];
  assign evt_count_o      = count_q;

  // ---- saturating coalesce counter ----
  logic [c_pop_w-1:0] w_drop_n;
  logic [DROP_W:0]    w_drop_sum;
  logic [DROP_W-1:0]  drop_q, drop_d;

  // Count coalesced events this cycle and add with saturation
  always_comb begin
    w_drop_n = '0;
    for (int k = 0; k < c_scan_w; k++) w_drop_n = w_drop_n + c_pop_w'(w_drop_vec[k]);
    w_drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(w_drop_n);
    if (clear_drops_i)          drop_d = '0;
    else if (w_drop_sum[DROP_W]) drop_d = '1;
    else                        drop_d = w_drop_sum[DROP_W-1:0];
  end

  // Drop counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  assign drop_count_o = drop_q;
endmodule
`default_nettype wire
